// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared widths, reset address and fetch state encoding
package pc_fetch_unit_pkg;

   localparam int PC_W    = 30;
   localparam int INSTR_W = 32;

   // Word address 0x0C00 is byte address 0x0000_3000
   localparam logic [PC_W-1:0] DEFAULT_RESET_ADDR = 30'h0000_0C00;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_ERROR = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_wait_timer.sv
// rtl/pc_fetch_unit_wait_timer.sv - fetch_wait_timer: counts unacknowledged request cycles, flags timeout
module fetch_wait_timer #(
   parameter int MAX_WAIT = 15,
   parameter int WAIT_W   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] CAP_WAIT  = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] wait_cnt;

   // Count enabled cycles; parks at MAX_WAIT so it can never wrap back to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (clear) begin
         wait_cnt <= '0;
      end else if (enable && (wait_cnt != CAP_WAIT)) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // The MAX_WAIT-th unacknowledged request cycle is the last one allowed
   assign timeout = enable && (wait_cnt == LAST_WAIT);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and req/ack instruction fetch; optional FETCH_PERF_CNT_EN counters
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_ADDR = DEFAULT_RESET_ADDR,
   parameter int              MAX_WAIT   = 15,
   parameter int              WAIT_W     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PC_W-1:0]    Next_I_Addr,
   input  logic               advance,
   input  logic               stall,
   output logic [PC_W-1:0]    PC_Addr,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]        perf_fetches,
   output logic [31:0]        perf_wait_cycles,
`endif
   output logic               fetch_err
);

   fetch_state_t      state;
   logic [PC_W-1:0]   pc;
   logic              wait_clear;
   logic              wait_enable;
   logic              wait_timeout;

   // Counter restarts on every completed fetch and while parked in HOLD
   assign wait_clear  = (state == ST_HOLD) || ((state == ST_FETCH) && imem_ack);
   assign wait_enable = (state == ST_FETCH) && !imem_ack;

   fetch_wait_timer #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (wait_clear),
      .enable  (wait_enable),
      .timeout (wait_timeout)
   );

   // Fetch sequencer; every output is a register so the PC is stable all through HOLD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_BOOT;
         pc          <= RESET_ADDR;
         instr       <= '0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               state    <= ST_FETCH;
               imem_req <= 1'b1;
            end
            ST_FETCH: begin
               // An ack on the final allowed cycle still wins over the timeout
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= ST_HOLD;
               end else if (wait_timeout) begin
                  fetch_err <= 1'b1;
                  imem_req  <= 1'b0;
                  state     <= ST_ERROR;
               end
            end
            ST_HOLD: begin
               if (advance && !stall) begin
                  pc          <= Next_I_Addr;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= ST_FETCH;
               end
            end
            default: begin
               // ST_ERROR holds everything until the next reset
               state <= ST_ERROR;
            end
         endcase
      end
   end

   assign PC_Addr   = pc;
   assign imem_addr = pc;

`ifdef FETCH_PERF_CNT_EN
   // Saturating counts of completed fetches and of FETCH cycles spent waiting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetches     <= '0;
         perf_wait_cycles <= '0;
      end else if (state == ST_FETCH) begin
         if (imem_ack) begin
            if (perf_fetches != 32'hFFFF_FFFF) begin
               perf_fetches <= perf_fetches + 32'd1;
            end
         end else if (perf_wait_cycles != 32'hFFFF_FFFF) begin
            perf_wait_cycles <= perf_wait_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit against a behavioural fetch model
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [29:0] Next_I_Addr;
   logic        advance;
   logic        stall;
   logic [29:0] PC_Addr;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetches;
   logic [31:0] perf_wait_cycles;
`endif

   int          compared;
   int          mismatched;
   logic [29:0] exp_pc;
   logic [31:0] exp_instr;

   pc_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .Next_I_Addr (Next_I_Addr),
      .advance     (advance),
      .stall       (stall),
      .PC_Addr     (PC_Addr),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetches     (perf_fetches),
      .perf_wait_cycles (perf_wait_cycles),
`endif
      .fetch_err   (fetch_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Contents of the modelled instruction memory at a word address
   function automatic logic [31:0] mem_word(input logic [29:0] a);
      return {a[13:0], a[29:12]} ^ 32'hA5C3_0F96;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; advance = 1'b0; stall = 1'b0; imem_ack = 1'b0;
      imem_rdata = '0; Next_I_Addr = '0;
      #2 rst_n = 1'b0;
      #1;
      compared += 5;
      if (PC_Addr !== 30'h0C00) begin mismatched++; $display("FAIL reset_pc: got %h want %h", PC_Addr, 30'h0C00); end
      if (imem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %b want 0", imem_req); end
      if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      if (instr !== 32'h0) begin mismatched++; $display("FAIL reset_instr: got %h want 0", instr); end
      if (fetch_err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", fetch_err); end
      tick(); tick();
      compared++;
      if (imem_req !== 1'b0) begin mismatched++; $display("FAIL reset_hold_req: got %b want 0", imem_req); end
   endtask

   task automatic test_first_fetch();
      rst_n = 1'b1;
      tick();
      compared += 3;
      if (imem_req !== 1'b1) begin mismatched++; $display("FAIL boot_req: got %b want 1", imem_req); end
      if (imem_addr !== 30'h0C00) begin mismatched++; $display("FAIL boot_addr: got %h want %h", imem_addr, 30'h0C00); end
      if (PC_Addr !== 30'h0C00) begin mismatched++; $display("FAIL boot_pc: got %h want %h", PC_Addr, 30'h0C00); end
      imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
      tick();
      imem_ack = 1'b0; imem_rdata = $urandom();
      compared += 3;
      if (instr !== 32'h2008_0005) begin mismatched++; $display("FAIL boot_instr: got %h want %h", instr, 32'h2008_0005); end
      if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL boot_valid: got %b want 1", instr_valid); end
      if (imem_req !== 1'b0) begin mismatched++; $display("FAIL boot_req_drop: got %b want 0", imem_req); end
      exp_pc = 30'h0C00; exp_instr = 32'h2008_0005;
   endtask

   task automatic test_advance();
      Next_I_Addr = 30'h0C01; advance = 1'b1;
      tick();
      advance = 1'b0;
      compared += 3;
      if (PC_Addr !== 30'h0C01) begin mismatched++; $display("FAIL adv_pc: got %h want %h", PC_Addr, 30'h0C01); end
      if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL adv_valid: got %b want 0", instr_valid); end
      if (imem_req !== 1'b1) begin mismatched++; $display("FAIL adv_req: got %b want 1", imem_req); end
      imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
      tick();
      imem_ack = 1'b0;
      exp_pc = 30'h0C01; exp_instr = mem_word(30'h0C01);
      compared += 2;
      if (instr !== exp_instr) begin mismatched++; $display("FAIL adv_instr: got %h want %h", instr, exp_instr); end
      if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL adv_valid2: got %b want 1", instr_valid); end
   endtask

   task automatic test_stall();
      advance = 1'b1; stall = 1'b1; Next_I_Addr = 30'($urandom());
      for (int c = 0; c < 3; c++) begin
         imem_ack = 1'b1; imem_rdata = $urandom();
         tick();
         compared += 4;
         if (PC_Addr !== exp_pc) begin mismatched++; $display("FAIL stall_pc: got %h want %h", PC_Addr, exp_pc); end
         if (instr !== exp_instr) begin mismatched++; $display("FAIL stall_instr: got %h want %h", instr, exp_instr); end
         if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL stall_valid: got %b want 1", instr_valid); end
         if (imem_req !== 1'b0) begin mismatched++; $display("FAIL stall_req: got %b want 0", imem_req); end
      end
      advance = 1'b0; stall = 1'b0; imem_ack = 1'b0;
   endtask

   task automatic test_wait_states();
      Next_I_Addr = 30'h0C02; advance = 1'b1;
      tick();
      advance = 1'b0;
      for (int c = 0; c < 4; c++) begin
         imem_ack = (c == 3);
         imem_rdata = (c == 3) ? 32'h0800_0C00 : $urandom();
         compared += 2;
         if (imem_req !== 1'b1) begin mismatched++; $display("FAIL wait_req: cycle %0d got %b want 1", c, imem_req); end
         if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL wait_valid_early: cycle %0d got %b want 0", c, instr_valid); end
         tick();
      end
      imem_ack = 1'b0;
      exp_pc = 30'h0C02; exp_instr = 32'h0800_0C00;
      compared += 3;
      if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL wait_valid: got %b want 1", instr_valid); end
      if (instr !== exp_instr) begin mismatched++; $display("FAIL wait_instr: got %h want %h", instr, exp_instr); end
      if (fetch_err !== 1'b0) begin mismatched++; $display("FAIL wait_err: got %b want 0", fetch_err); end
   endtask

   task automatic test_timeout();
      int n;
      Next_I_Addr = 30'h0C03; advance = 1'b1;
      tick();
      advance = 1'b0; imem_ack = 1'b0;
      n = 0;
      while (imem_req && n < 40) begin
         n++;
         tick();
      end
      compared += 4;
      if (n != 15) begin mismatched++; $display("FAIL to_req_cycles: got %0d want 15", n); end
      if (fetch_err !== 1'b1) begin mismatched++; $display("FAIL to_err: got %b want 1", fetch_err); end
      if (imem_req !== 1'b0) begin mismatched++; $display("FAIL to_req: got %b want 0", imem_req); end
      if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL to_valid: got %b want 0", instr_valid); end
      advance = 1'b1; Next_I_Addr = 30'h0C55;
      for (int c = 0; c < 3; c++) begin
         imem_ack = 1'b1; imem_rdata = $urandom();
         tick();
         compared += 4;
         if (PC_Addr !== 30'h0C03) begin mismatched++; $display("FAIL err_pc: got %h want %h", PC_Addr, 30'h0C03); end
         if (imem_req !== 1'b0) begin mismatched++; $display("FAIL err_req: got %b want 0", imem_req); end
         if (fetch_err !== 1'b1) begin mismatched++; $display("FAIL err_sticky: got %b want 1", fetch_err); end
         if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL err_valid: got %b want 0", instr_valid); end
      end
      advance = 1'b0; imem_ack = 1'b0;
      rst_n = 1'b0;
      #1;
      compared += 2;
      if (PC_Addr !== 30'h0C00) begin mismatched++; $display("FAIL err_rst_pc: got %h want %h", PC_Addr, 30'h0C00); end
      if (fetch_err !== 1'b0) begin mismatched++; $display("FAIL err_rst_err: got %b want 0", fetch_err); end
      tick();
      rst_n = 1'b1;
      tick();
      imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
      tick();
      imem_ack = 1'b0;
      exp_pc = 30'h0C00; exp_instr = mem_word(30'h0C00);
      compared += 2;
      if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL err_reboot_valid: got %b want 1", instr_valid); end
      if (instr !== exp_instr) begin mismatched++; $display("FAIL err_reboot_instr: got %h want %h", instr, exp_instr); end
   endtask

   task automatic test_wrap_and_async_reset();
      logic [29:0] nx;
      Next_I_Addr = 30'h3FFF_FFFF; advance = 1'b1;
      tick();
      advance = 1'b0;
      imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
      tick();
      imem_ack = 1'b0;
      exp_pc = 30'h3FFF_FFFF; exp_instr = mem_word(30'h3FFF_FFFF);
      compared += 2;
      if (PC_Addr !== exp_pc) begin mismatched++; $display("FAIL wrap_top_pc: got %h want %h", PC_Addr, exp_pc); end
      if (instr !== exp_instr) begin mismatched++; $display("FAIL wrap_top_instr: got %h want %h", instr, exp_instr); end
      nx = exp_pc + 30'd1;
      Next_I_Addr = nx; advance = 1'b1;
      tick();
      advance = 1'b0;
      compared += 2;
      if (PC_Addr !== 30'h0) begin mismatched++; $display("FAIL wrap_pc: got %h want 0", PC_Addr); end
      if (imem_req !== 1'b1) begin mismatched++; $display("FAIL wrap_req: got %b want 1", imem_req); end
      #3 rst_n = 1'b0;
      #1;
      compared += 2;
      if (imem_req !== 1'b0) begin mismatched++; $display("FAIL async_req: got %b want 0", imem_req); end
      if (PC_Addr !== 30'h0C00) begin mismatched++; $display("FAIL async_pc: got %h want %h", PC_Addr, 30'h0C00); end
      tick();
      rst_n = 1'b1;
      tick();
      imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
      tick();
      imem_ack = 1'b0;
      exp_pc = 30'h0C00; exp_instr = mem_word(30'h0C00);
      compared++;
      if (instr !== exp_instr) begin mismatched++; $display("FAIL async_reboot_instr: got %h want %h", instr, exp_instr); end
   endtask

   task automatic test_random();
      int lat;
      int cycles;
      int fetches;
      int waits;
`ifdef FETCH_PERF_CNT_EN
      logic [31:0] pf0;
      logic [31:0] pw0;
      pf0 = perf_fetches; pw0 = perf_wait_cycles;
`endif
      fetches = 0; waits = 0;
      for (int i = 0; i < 40; i++) begin
         // Stalled advances, plus stray acks with no request outstanding
         for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
            advance = 1'b1; stall = 1'b1; Next_I_Addr = 30'($urandom());
            imem_ack = 1'($urandom()); imem_rdata = $urandom();
            tick();
            compared += 2;
            if (PC_Addr !== exp_pc) begin mismatched++; $display("FAIL rnd_stall_pc: got %h want %h", PC_Addr, exp_pc); end
            if (instr !== exp_instr) begin mismatched++; $display("FAIL rnd_stall_instr: got %h want %h", instr, exp_instr); end
         end
         imem_ack = 1'b0; stall = 1'b0; advance = 1'b1;
         Next_I_Addr = 30'($urandom());
         exp_pc = Next_I_Addr;
         exp_instr = mem_word(exp_pc);
         tick();
         advance = 1'b0;
         compared++;
         if (PC_Addr !== exp_pc) begin mismatched++; $display("FAIL rnd_pc: got %h want %h", PC_Addr, exp_pc); end
         lat = $urandom_range(0, 6);
         cycles = 0;
         while (!instr_valid && cycles < 20) begin
            imem_ack = (cycles == lat);
            imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom();
            tick();
            cycles++;
         end
         imem_ack = 1'b0;
         fetches++; waits += lat;
         compared += 3;
         if (cycles != lat + 1) begin mismatched++; $display("FAIL rnd_latency: got %0d want %0d", cycles, lat + 1); end
         if (instr !== exp_instr) begin mismatched++; $display("FAIL rnd_instr: got %h want %h", instr, exp_instr); end
         if (fetch_err !== 1'b0) begin mismatched++; $display("FAIL rnd_err: got %b want 0", fetch_err); end
      end
`ifdef FETCH_PERF_CNT_EN
      compared += 2;
      if (perf_fetches - pf0 !== 32'(fetches)) begin mismatched++; $display("FAIL perf_fetches: got %0d want %0d", perf_fetches - pf0, fetches); end
      if (perf_wait_cycles - pw0 !== 32'(waits)) begin mismatched++; $display("FAIL perf_waits: got %0d want %0d", perf_wait_cycles - pw0, waits); end
`endif
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      test_reset();
      test_first_fetch();
      test_advance();
      test_stall();
      test_wait_states();
      test_timeout();
      test_wrap_and_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
